exc_ctrl: RTL and testbench
===========================

// Module: exc_ctrl
// PURPOSE
//  Exception/interrupt decision block at the MEM/WB boundary; drives CP0's exception-commit interface.
//  Merges MEM-stage exception flags with async external interrupts (synchronized here) and
//  WB-bypassed CP0 STATUS/CAUSE/EPC. Emits excepttype/EPC-source/delay-slot info to CP0, a
//  multi-cycle pipeline flush and the redirect PC to the fetch stage.
// PARAMETERS
//  EXC_VECTOR    32'h00000020  redirect PC for every exception except eret
//  FLUSH_CYCLES  2             cycles flush_o is high per accepted event (>=1)
//  SYNC_STAGES   2             flop stages on int_i (>=2)
// PORTS
//  clk                 in   1   clock, all state on posedge
//  rst                 in   1   asynchronous, active-low reset
//  int_i               in   6   external hw interrupt lines, asynchronous
//  int_sync_o          out  6   synchronized int_i, feeds CP0 CAUSE[15:10]
//  mem_valid_i         in   1   real (non-bubble) instruction in MEM
//  mem_pc_i            in   32  PC of MEM instruction
//  mem_in_delayslot_i  in   1   MEM instruction sits in a branch delay slot
//  mem_syscall_i       in   1   syscall flag
//  mem_inst_invalid_i  in   1   reserved-instruction flag
//  mem_trap_i          in   1   trap-taken flag
//  mem_ov_i            in   1   arithmetic overflow flag
//  mem_eret_i          in   1   eret flag
//  cp0_status_i        in   32  CP0 STATUS (reg 12)
//  cp0_cause_i         in   32  CP0 CAUSE (reg 13)
//  cp0_epc_i           in   32  CP0 EPC (reg 14)
//  wb_cp0_we_i         in   1   CP0 write pending in WB
//  wb_cp0_waddr_i      in   5   its target register
//  wb_cp0_data_i       in   32  its data
//  excepttype_o        out  32  event code to CP0 (0 = none)
//  current_inst_addr_o out  32  PC to CP0 for EPC
//  is_in_delayslot_o   out  1   delay-slot flag to CP0
//  flush_o             out  1   flush IF..MEM
//  new_pc_o            out  32  redirect target, valid while flush_o=1
//  busy_o              out  1   FSM in FLUSH state
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, sync chain=0, counter=0, held PC=0; all outputs 0.
//  Bypass: status=(we&&waddr==12)?wb_data:cp0_status; epc likewise for 14; cause=cp0_cause
//   except bits[9:8] taken from wb_data when we&&waddr==13. WB data wins over CP0 value.
//  Interrupt pending = |(cause[15:8] & status[15:8]) && status[0](IE) && !status[1](EXL).
//  Code (IDLE, mem_valid_i=1 only; fixed priority, first match):
//   int 32'h1 > syscall 32'h8 > inst_invalid 32'ha > trap 32'hd > ov 32'hc > eret 32'he.
//   No match or mem_valid_i=0 -> 32'h0. mem_valid_i=0 blocks interrupts too.
//  excepttype_o/current_inst_addr_o/is_in_delayslot_o: combinational, zero latency; CP0 commits
//   them on the same edge. current_inst_addr_o=mem_pc_i; delay-slot EPC -4 adjust belongs to CP0.
//  FSM IDLE: code!=0 -> flush_o=1 same cycle; new_pc_o=(code==e)?bypassed epc:EXC_VECTOR.
//   Target latched at the edge; FSM -> FLUSH with cnt=FLUSH_CYCLES-1 (stays IDLE if that is 0).
//  FSM FLUSH: flush_o=1, busy_o=1, new_pc_o=latched target; excepttype_o forced 0 (MEM flags
//   come from squashed instrs). cnt decrements each cycle; cnt==1 -> IDLE at next edge.
//   Exactly FLUSH_CYCLES consecutive flush cycles per event. No back-to-back acceptance.
//  IDLE, no event: flush_o=0, new_pc_o=0.
//  Interrupt during FLUSH: not taken; re-evaluated in IDLE once MEM holds a valid instr.
//  eret with pending interrupt in same cycle: interrupt masked by EXL=1 -> eret taken.
//  int_i latency: SYNC_STAGES edges to int_sync_o; edge-blind, level only.
//  Reset mid-FLUSH: immediate return to IDLE, flush_o=0, no residual redirect.
// TESTING
//  1 syscall: mem_valid=1,syscall=1,pc=0x100 -> excepttype=0x8, addr=0x100, flush 2 cycles,
//    new_pc=0x20 both cycles.
//  2 priority: ov+inst_invalid+trap same cycle -> excepttype=0xa only; MEM flags during FLUSH -> 0.
//  3 interrupt: status=0x0000_0401, int_i[0]=1 -> after 2 edges int_sync_o=1; with cause[10]
//    fed back -> code 0x1. status[1]=1 or mem_valid=0 -> 0x0.
//  4 eret bypass: cp0_epc=0x40, WB writes reg14=0x80 same cycle -> code 0xe, new_pc=0x80;
//    no WB write -> new_pc=0x40.
//  5 sw-int bypass: status=0x0100_0101 (IM0,IE), cause=0, WB writes reg13 data 0x100 -> code 0x1.
//  6 reset: rst=0 in first FLUSH cycle -> flush_o,busy_o,new_pc_o=0 at once; after release,
//    IDLE and no flush.

Source files
------------

// File: rtl/exc_ctrl.sv
//-----------------------------------------------------------------------------
// exc_ctrl -- exception / interrupt decision block at the MEM/WB boundary.
//
// Merges the MEM-stage exception flags with the synchronized external
// interrupt lines and the CP0 STATUS/CAUSE/EPC values. A CP0 write still
// sitting in WB is bypassed over the CP0 copy. The block produces:
//   * the exception-commit fields for CP0. These are combinational, because
//     CP0 commits them on the same edge.
//   * a multi-cycle pipeline flush and the redirect PC for the fetch stage.
//
// Ports
//   clk, rst                 clock (posedge) and asynchronous active-low reset
//   int_i / int_sync_o       raw external interrupt lines / synchronized copy
//   mem_*_i                  MEM-stage instruction info and exception flags
//   cp0_status/cause/epc_i   CP0 registers 12 / 13 / 14
//   wb_cp0_we/waddr/data_i   CP0 write pending in WB (bypass source)
//   excepttype_o             event code to CP0 (0 = none)
//   current_inst_addr_o      PC of the MEM instruction, for EPC
//   is_in_delayslot_o        delay-slot flag to CP0
//   flush_o / new_pc_o       flush IF..MEM / redirect target
//   busy_o                   high while the flush sequence is running
//-----------------------------------------------------------------------------
module exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  int_i,
   output logic [5:0]  int_sync_o,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_delayslot_i,
   input  logic        mem_syscall_i,
   input  logic        mem_inst_invalid_i,
   input  logic        mem_trap_i,
   input  logic        mem_ov_i,
   input  logic        mem_eret_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   output logic [31:0] excepttype_o,
   output logic [31:0] current_inst_addr_o,
   output logic        is_in_delayslot_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        busy_o
);

   localparam logic [31:0] CODE_NONE    = 32'h0000_0000;
   localparam logic [31:0] CODE_INT     = 32'h0000_0001;
   localparam logic [31:0] CODE_SYSCALL = 32'h0000_0008;
   localparam logic [31:0] CODE_INVALID = 32'h0000_000a;
   localparam logic [31:0] CODE_TRAP    = 32'h0000_000d;
   localparam logic [31:0] CODE_OV      = 32'h0000_000c;
   localparam logic [31:0] CODE_ERET    = 32'h0000_000e;

   localparam int                CNT_W   = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_RLD = CNT_W'(FLUSH_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   // Fixed-priority event selection. A bubble in MEM blocks every event,
   // interrupts included.
   function automatic logic [31:0] pick_code(
      input logic valid,
      input logic int_pend,
      input logic sys,
      input logic inv,
      input logic trap,
      input logic ov,
      input logic eret
   );
      logic [31:0] code;
      if (!valid) begin
         code = CODE_NONE;
      end else if (int_pend) begin
         code = CODE_INT;
      end else if (sys) begin
         code = CODE_SYSCALL;
      end else if (inv) begin
         code = CODE_INVALID;
      end else if (trap) begin
         code = CODE_TRAP;
      end else if (ov) begin
         code = CODE_OV;
      end else if (eret) begin
         code = CODE_ERET;
      end else begin
         code = CODE_NONE;
      end
      return code;
   endfunction

   state_t            state_r, state_nx;
   logic [CNT_W-1:0]  cnt_r, cnt_nx;
   logic [31:0]       held_pc_r, held_pc_nx;
   logic [5:0]        sync_r [SYNC_STAGES];

   logic [31:0] status_s;
   logic [31:0] epc_s;
   logic [15:8] cause_hi_s;
   logic        int_pend_s;
   logic [31:0] code_s;
   logic [31:0] target_s;
   logic [31:0] exc_s;
   logic        flush_s;
   logic        busy_s;
   logic [31:0] new_pc_s;
   logic        unused_s;

   // Interrupt synchronizer: level only, SYNC_STAGES flops deep.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= 6'b00_0000;
         end
      end else begin
         sync_r[0] <= int_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   assign int_sync_o = sync_r[SYNC_STAGES-1];

   // WB bypass. Only the software-interrupt bits of CAUSE (IP1..IP0) are
   // writable, so only those are taken from WB.
   always_comb begin
      status_s   = cp0_status_i;
      epc_s      = cp0_epc_i;
      cause_hi_s = cp0_cause_i[15:8];
      if (wb_cp0_we_i && (wb_cp0_waddr_i == 5'd12)) begin
         status_s = wb_cp0_data_i;
      end else begin
         status_s = cp0_status_i;
      end
      if (wb_cp0_we_i && (wb_cp0_waddr_i == 5'd14)) begin
         epc_s = wb_cp0_data_i;
      end else begin
         epc_s = cp0_epc_i;
      end
      if (wb_cp0_we_i && (wb_cp0_waddr_i == 5'd13)) begin
         cause_hi_s[9:8] = wb_cp0_data_i[9:8];
      end else begin
         cause_hi_s[9:8] = cp0_cause_i[9:8];
      end
   end

   // A set EXL masks interrupts. An eret that arrives together with a
   // pending interrupt is therefore taken as an eret.
   assign int_pend_s = (|(cause_hi_s & status_s[15:8])) & status_s[0] & ~status_s[1];
   assign code_s     = pick_code(mem_valid_i, int_pend_s, mem_syscall_i, mem_inst_invalid_i,
                                 mem_trap_i, mem_ov_i, mem_eret_i);
   assign target_s   = (code_s == CODE_ERET) ? epc_s : EXC_VECTOR;

   // FSM state, flush counter and latched redirect target.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         held_pc_r <= 32'h0000_0000;
      end else begin
         state_r   <= state_nx;
         cnt_r     <= cnt_nx;
         held_pc_r <= held_pc_nx;
      end
   end

   // Next-state logic and flush/redirect outputs.
   always_comb begin
      state_nx   = state_r;
      cnt_nx     = cnt_r;
      held_pc_nx = held_pc_r;
      exc_s      = CODE_NONE;
      flush_s    = 1'b0;
      busy_s     = 1'b0;
      new_pc_s   = 32'h0000_0000;
      case (state_r)
         ST_IDLE: begin
            exc_s = code_s;
            if (code_s != CODE_NONE) begin
               flush_s    = 1'b1;
               new_pc_s   = target_s;
               held_pc_nx = target_s;
               if (FLUSH_CYCLES > 1) begin
                  state_nx = ST_FLUSH;
                  cnt_nx   = CNT_RLD;
               end else begin
                  state_nx = ST_IDLE;
                  cnt_nx   = '0;
               end
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            // The MEM flags here come from squashed instructions. They are
            // ignored, and no new event can be accepted until IDLE.
            flush_s  = 1'b1;
            busy_s   = 1'b1;
            new_pc_s = held_pc_r;
            if (cnt_r <= CNT_ONE) begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt_r - CNT_ONE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Outputs are forced low for as long as reset is asserted. This makes
   // sure a reset in the middle of a flush leaves no redirect behind, even
   // when MEM still shows an event.
   assign excepttype_o        = rst ? exc_s : 32'h0000_0000;
   assign current_inst_addr_o = rst ? mem_pc_i : 32'h0000_0000;
   assign is_in_delayslot_o   = rst & mem_in_delayslot_i;
   assign flush_o             = rst & flush_s;
   assign busy_o              = rst & busy_s;
   assign new_pc_o            = rst ? new_pc_s : 32'h0000_0000;

   assign unused_s = ^{cp0_cause_i[31:16], cp0_cause_i[7:0], status_s[31:16], status_s[7:2]};

endmodule

// File: tb/tb_exc_ctrl.sv
//-----------------------------------------------------------------------------
// tb_exc_ctrl -- scoreboard bench for exc_ctrl.
// Each stimulus vector is driven just after a rising edge. Its expected
// response comes from a transaction-level reference model and is queued.
// A monitor samples the outputs on the falling edge and checks them against
// the head of the queue.
//-----------------------------------------------------------------------------
module tb_exc_ctrl;

   typedef struct {
      logic        rst;
      logic        valid;
      logic [31:0] pc;
      logic        ds, sys, inv, trap, ov, eret;
      logic [31:0] status, cause, epc;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [5:0]  intl;
   } stim_t;

   typedef struct {
      logic [31:0] exc, addr, npc;
      logic        ds, flush, busy;
      logic [5:0]  isync;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  int_i = 6'd0;
   logic [5:0]  int_sync_o;
   logic        mem_valid_i = 1'b0, mem_in_delayslot_i = 1'b0;
   logic [31:0] mem_pc_i = 32'd0;
   logic        mem_syscall_i = 1'b0, mem_inst_invalid_i = 1'b0, mem_trap_i = 1'b0;
   logic        mem_ov_i = 1'b0, mem_eret_i = 1'b0;
   logic [31:0] cp0_status_i = 32'd0, cp0_cause_i = 32'd0, cp0_epc_i = 32'd0;
   logic        wb_cp0_we_i = 1'b0;
   logic [4:0]  wb_cp0_waddr_i = 5'd0;
   logic [31:0] wb_cp0_data_i = 32'd0;
   logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o;
   logic        is_in_delayslot_o, flush_o, busy_o;

   exc_ctrl dut (
      .clk(clk), .rst(rst), .int_i(int_i), .int_sync_o(int_sync_o),
      .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_in_delayslot_i(mem_in_delayslot_i),
      .mem_syscall_i(mem_syscall_i), .mem_inst_invalid_i(mem_inst_invalid_i),
      .mem_trap_i(mem_trap_i), .mem_ov_i(mem_ov_i), .mem_eret_i(mem_eret_i),
      .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
      .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
      .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
      .is_in_delayslot_o(is_in_delayslot_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model state: remaining flush cycles after an accepted event,
   // the redirect target, and the int_i values driven one and two vectors ago.
   int          m_left = 0;
   logic [31:0] m_held = 32'd0;
   logic [5:0]  m_h1 = 6'd0, m_h2 = 6'd0;

   function automatic stim_t quiet();
      stim_t s;
      s.rst = 1'b1; s.valid = 1'b1; s.pc = 32'h0; s.ds = 1'b0;
      s.sys = 1'b0; s.inv = 1'b0; s.trap = 1'b0; s.ov = 1'b0; s.eret = 1'b0;
      s.status = 32'h0; s.cause = 32'h0; s.epc = 32'h0;
      s.we = 1'b0; s.waddr = 5'd0; s.wdata = 32'h0; s.intl = 6'd0;
      return s;
   endfunction

   // Reference model for one cycle, worked out from the architectural rules.
   function automatic exp_t model(input stim_t s);
      exp_t        e;
      logic [31:0] st, ep, ca, code;
      logic        ip;
      e.exc = 32'h0; e.addr = 32'h0; e.npc = 32'h0;
      e.ds = 1'b0; e.flush = 1'b0; e.busy = 1'b0; e.isync = 6'd0;
      if (!s.rst) begin
         m_left = 0; m_h1 = 6'd0; m_h2 = 6'd0;
         return e;
      end
      e.isync = m_h2;
      m_h2 = m_h1;
      m_h1 = s.intl;
      e.addr = s.pc;
      e.ds   = s.ds;
      st = (s.we && s.waddr == 5'd12) ? s.wdata : s.status;
      ep = (s.we && s.waddr == 5'd14) ? s.wdata : s.epc;
      ca = s.cause;
      if (s.we && s.waddr == 5'd13) ca[9:8] = s.wdata[9:8];
      ip = ((ca[15:8] & st[15:8]) != 8'd0) && st[0] && !st[1];
      if (m_left > 0) begin
         e.flush = 1'b1; e.busy = 1'b1; e.npc = m_held;
         m_left = m_left - 1;
         return e;
      end
      code = 32'h0;
      if (s.valid) begin
         if (ip)          code = 32'h1;
         else if (s.sys)  code = 32'h8;
         else if (s.inv)  code = 32'ha;
         else if (s.trap) code = 32'hd;
         else if (s.ov)   code = 32'hc;
         else if (s.eret) code = 32'he;
      end
      e.exc = code;
      if (code != 32'h0) begin
         e.flush = 1'b1;
         e.npc   = (code == 32'he) ? ep : 32'h20;
         m_held  = e.npc;
         m_left  = 2 - 1;
      end
      return e;
   endfunction

   task automatic apply(input stim_t s);
      @(posedge clk);
      #1;
      rst = s.rst; mem_valid_i = s.valid; mem_pc_i = s.pc; mem_in_delayslot_i = s.ds;
      mem_syscall_i = s.sys; mem_inst_invalid_i = s.inv; mem_trap_i = s.trap;
      mem_ov_i = s.ov; mem_eret_i = s.eret;
      cp0_status_i = s.status; cp0_cause_i = s.cause; cp0_epc_i = s.epc;
      wb_cp0_we_i = s.we; wb_cp0_waddr_i = s.waddr; wb_cp0_data_i = s.wdata;
      int_i = s.intl;
      sb_q.push_back(model(s));
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s vector %0d: got 0x%08h, expected 0x%08h", name, vectors, act, exp);
      end
   endtask

   // Monitor: checks the DUT outputs mid-cycle against the queued expectation.
   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         exp_t e;
         e = sb_q.pop_front();
         vectors++;
         cmp("excepttype", excepttype_o, e.exc);
         cmp("inst_addr", current_inst_addr_o, e.addr);
         cmp("delayslot", {31'd0, is_in_delayslot_o}, {31'd0, e.ds});
         cmp("flush", {31'd0, flush_o}, {31'd0, e.flush});
         cmp("busy", {31'd0, busy_o}, {31'd0, e.busy});
         cmp("new_pc", new_pc_o, e.npc);
         cmp("int_sync", {26'd0, int_sync_o}, {26'd0, e.isync});
      end
   end

   initial begin
      stim_t s;
      logic [31:0] r;
      // reset state
      s = quiet(); s.rst = 1'b0; s.sys = 1'b1;
      apply(s); apply(s);
      // 1: syscall, two flush cycles to vector
      s = quiet(); s.sys = 1'b1; s.pc = 32'h100; apply(s);
      s = quiet(); s.ov = 1'b1; s.pc = 32'h104; apply(s);
      s = quiet(); apply(s);
      // 2: priority and flags ignored during flush
      s = quiet(); s.ov = 1'b1; s.inv = 1'b1; s.trap = 1'b1; s.pc = 32'h200; apply(s);
      s = quiet(); s.sys = 1'b1; s.eret = 1'b1; apply(s);
      s = quiet(); s.trap = 1'b1; s.ov = 1'b1; apply(s);
      s = quiet(); s.ov = 1'b1; s.eret = 1'b1; apply(s);
      s = quiet(); apply(s);
      // 3: interrupt through synchronizer, CAUSE fed back from int_sync
      for (int i = 0; i < 4; i++) begin
         s = quiet(); s.valid = (i == 3); s.status = 32'h0000_0401; s.intl = 6'd1;
         s.cause = {16'd0, m_h2, 10'd0}; apply(s);
      end
      s = quiet(); s.status = 32'h0000_0401; s.intl = 6'd1; s.cause = 32'h400; apply(s);
      s = quiet(); s.status = 32'h0000_0403; s.intl = 6'd1; s.cause = 32'h400; apply(s);
      s = quiet(); s.valid = 1'b0; s.status = 32'h0000_0401; s.cause = 32'h400; apply(s);
      // eret with pending int under EXL
      s = quiet(); s.status = 32'h0000_0403; s.cause = 32'h400; s.eret = 1'b1; s.epc = 32'h44;
      apply(s);
      s = quiet(); apply(s);
      // 4: eret with EPC bypass, then without it
      s = quiet(); s.eret = 1'b1; s.epc = 32'h40; s.we = 1'b1; s.waddr = 5'd14;
      s.wdata = 32'h80; apply(s);
      s = quiet(); apply(s);
      s = quiet(); s.eret = 1'b1; s.epc = 32'h40; apply(s);
      s = quiet(); apply(s);
      // 5: software interrupt via CAUSE bypass
      s = quiet(); s.status = 32'h0100_0101; s.we = 1'b1; s.waddr = 5'd13;
      s.wdata = 32'h100; apply(s);
      s = quiet(); apply(s);
      // 6: reset in the first flush cycle
      s = quiet(); s.sys = 1'b1; s.pc = 32'h300; apply(s);
      s = quiet(); s.rst = 1'b0; s.sys = 1'b1; apply(s);
      s = quiet(); s.valid = 1'b0; apply(s);
      s = quiet(); s.valid = 1'b0; apply(s);
      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         s = quiet();
         s.rst   = ($urandom_range(0, 79) != 0);
         s.valid = ($urandom_range(0, 4) != 0);
         r = $urandom; s.pc = {r[31:2], 2'b00};
         s.ds    = $urandom_range(0, 1) == 1;
         s.sys   = $urandom_range(0, 6) == 0;
         s.inv   = $urandom_range(0, 6) == 0;
         s.trap  = $urandom_range(0, 6) == 0;
         s.ov    = $urandom_range(0, 6) == 0;
         s.eret  = $urandom_range(0, 6) == 0;
         s.status = $urandom;
         s.status[1] = ($urandom_range(0, 3) == 0);
         s.status[0] = ($urandom_range(0, 3) != 0);
         s.cause = $urandom;
         if ($urandom_range(0, 1) == 1) s.cause[15:10] = m_h2;
         s.epc   = $urandom;
         s.we    = $urandom_range(0, 2) == 0;
         case ($urandom_range(0, 3))
            0: s.waddr = 5'd12;
            1: s.waddr = 5'd13;
            2: s.waddr = 5'd14;
            default: s.waddr = 5'($urandom_range(0, 31));
         endcase
         s.wdata = $urandom;
         s.intl  = 6'($urandom_range(0, 63));
         apply(s);
      end
      repeat (3) @(negedge clk);
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
